// File: rtl/systolic_acc_drain.sv
// Bottom-edge drain controller for the systolic PE array: captures each bottom row,
// streams it out column by column, then flushes the accumulator chain down one row.
module systolic_acc_drain #(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int ACC_BWIDTH = 32,
  localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW         = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       START,
  input  logic [COLS*ACC_BWIDTH-1:0] ACC_IN,
  output logic                       FLUSH_OUT,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [ACC_BWIDTH-1:0]      OUT_DATA,
  output logic [RW-1:0]              OUT_ROW,
  output logic [CW-1:0]              OUT_COL,
  output logic                       OUT_LAST
);

  // state   | meaning
  // IDLE    | waiting for START
  // CAPTURE | latch bottom-row accumulators into the row buffer
  // SEND    | stream buffer[col] until the last column is accepted
  // SHIFT   | one-cycle FLUSH_OUT, chain moves down one row
  // FINISH  | one-cycle DONE
  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SEND,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [ACC_BWIDTH-1:0] buf_q [COLS];
  logic [ACC_BWIDTH-1:0] buf_d [COLS];

  logic last_col, last_row;
  assign last_col = (col_q == CW'(COLS - 1));
  assign last_row = (row_q == RW'(ROWS - 1));

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      for (int c = 0; c < COLS; c++) buf_q[c] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_CAPTURE;
          row_d   = '0;
        end
      end
      S_CAPTURE: begin
        for (int c = 0; c < COLS; c++) buf_d[c] = ACC_IN[c*ACC_BWIDTH +: ACC_BWIDTH];
        col_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (OUT_READY) begin
          if (!last_col)     col_d   = col_q + CW'(1);
          else if (!last_row) state_d = S_SHIFT;
          else               state_d = S_FINISH;
        end
      end
      S_SHIFT: begin
        row_d   = row_q + RW'(1);
        state_d = S_CAPTURE;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Stream fields are forced to zero outside SEND so idle outputs read as all-zero.
  assign OUT_VALID = (state_q == S_SEND);
  assign FLUSH_OUT = (state_q == S_SHIFT);
  assign DONE      = (state_q == S_FINISH);
  assign BUSY      = (state_q != S_IDLE);
  assign OUT_DATA  = OUT_VALID ? buf_q[col_q] : '0;
  assign OUT_COL   = OUT_VALID ? col_q : '0;
  assign OUT_ROW   = OUT_VALID ? (RW'(ROWS - 1) - row_q) : '0;
  assign OUT_LAST  = OUT_VALID & last_row & last_col;

endmodule

// File: tb/tb_systolic_acc_drain.sv
// Scoreboard bench for systolic_acc_drain: a PE-array model feeds ACC_IN and shifts on FLUSH_OUT.
module tb_systolic_acc_drain;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int W    = 32;
  localparam int RW   = 2;
  localparam int CW   = 2;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              START = 1'b0;
  logic              OUT_READY = 1'b0;
  logic [COLS*W-1:0] ACC_IN;
  logic              FLUSH_OUT, BUSY, DONE, OUT_VALID, OUT_LAST;
  logic [W-1:0]      OUT_DATA;
  logic [RW-1:0]     OUT_ROW;
  logic [CW-1:0]     OUT_COL;

  always #5 CLK = ~CLK;

  systolic_acc_drain #(.ROWS(ROWS), .COLS(COLS), .ACC_BWIDTH(W)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .ACC_IN(ACC_IN),
    .FLUSH_OUT(FLUSH_OUT), .BUSY(BUSY), .DONE(DONE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_ROW(OUT_ROW), .OUT_COL(OUT_COL), .OUT_LAST(OUT_LAST)
  );

  // PE array model: row ROWS-1 is the bottom row; a flush moves every row down, top fills with 0.
  logic [W-1:0] pe      [ROWS][COLS];
  logic [W-1:0] pe_load [ROWS][COLS];
  logic         load_req = 1'b0;

  always @(posedge CLK) begin
    if (load_req) pe <= pe_load;
    else if (FLUSH_OUT) begin
      for (int r = ROWS - 1; r > 0; r--) pe[r] <= pe[r-1];
      for (int c = 0; c < COLS; c++) pe[0][c] <= '0;
    end
  end

  always_comb begin
    ACC_IN = '0;
    for (int c = 0; c < COLS; c++) ACC_IN[c*W +: W] = pe[ROWS-1][c];
  end

  typedef struct packed {
    logic [W-1:0]  data;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
  } item_t;

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    ready_mode = 0;
  int    flush_cnt = 0;
  int    done_cnt  = 0;
  int    done_cyc  = -1;
  int    first_valid_cyc = -1;
  int    start_cyc = 0;
  int    exp_done  = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Ready patterns: 0 = always ready, 1 = repeating 1,0,0, 2 = random.
  initial begin
    int ph = 0;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       OUT_READY = 1'b1;
        1:       OUT_READY = (ph % 3 == 0);
        default: OUT_READY = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stream/flush rules.
  logic        stalled_prev = 1'b0;
  logic        flush_prev   = 1'b0;
  logic [W+RW+CW-1:0] prev_word = '0;
  int          last_hs_col  = -1;

  always @(negedge CLK) begin
    item_t got, e;
    if (RSTn) begin
      got = {OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST};
      if (OUT_VALID && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stalled_prev)
        check(OUT_VALID && ({OUT_DATA, OUT_ROW, OUT_COL} == prev_word), "stall_hold",
              64'({OUT_DATA, OUT_ROW, OUT_COL}), 64'(prev_word));
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) check(1'b0, "unexpected_element", 64'(got), 64'(0));
        else begin
          e = exp_q.pop_front();
          check(got == e, "element", 64'(got), 64'(e));
        end
        last_hs_col = int'(OUT_COL);
      end
      if (FLUSH_OUT) begin
        flush_cnt++;
        check(!flush_prev && !OUT_VALID && last_hs_col == COLS - 1, "flush_placement",
              64'({flush_prev, OUT_VALID, 8'(last_hs_col)}), 64'(COLS - 1));
      end
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stalled_prev = OUT_VALID && !OUT_READY;
      prev_word    = {OUT_DATA, OUT_ROW, OUT_COL};
      flush_prev   = FLUSH_OUT;
    end else begin
      stalled_prev = 1'b0;
      flush_prev   = 1'b0;
    end
  end

  task automatic load_array(input int kind);
    logic [W-1:0] ext [4];
    ext[0] = 32'h7FFF_FFFF; ext[1] = 32'h8000_0000; ext[2] = 32'hFFFF_FFFF; ext[3] = 32'h0000_0000;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        case (kind)
          0:       pe_load[r][c] = W'(100 * r + c);
          1:       pe_load[r][c] = $urandom;
          default: pe_load[r][c] = ext[$urandom_range(0, 3)];
        endcase
    @(posedge CLK); #1 load_req = 1'b1;
    @(posedge CLK); #1 load_req = 1'b0;
  endtask

  // Expected drain order: bottom row first; after k flushes the bottom holds the snapshot's row ROWS-1-k.
  task automatic start_drain();
    @(posedge CLK); #1;
    for (int k = 0; k < ROWS; k++) begin
      int r = ROWS - 1 - k;
      for (int c = 0; c < COLS; c++)
        exp_q.push_back('{data: pe[r][c], row: RW'(r), col: CW'(c), last: (r == 0 && c == COLS - 1)});
    end
    START = 1'b1;
    start_cyc = cyc;
    first_valid_cyc = -1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge CLK);
    check(done_cnt == d0 + 1, "done_seen", 64'(done_cnt - d0), 64'(1));
    check(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 64'(0));
    exp_done++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    // Reset / idle
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check({FLUSH_OUT, BUSY, DONE, OUT_VALID, OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST} == '0,
            "idle_outputs_zero", 64'({BUSY, DONE, OUT_VALID, FLUSH_OUT, OUT_DATA}), 64'(0));
    end

    // Full drain, always ready, PE(r,c) = 100r+c
    ready_mode = 0;
    load_array(0);
    flush_cnt = 0;
    start_drain();
    wait_done(200);
    check(first_valid_cyc - start_cyc == 2, "first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'(2));
    check(done_cyc - start_cyc == 1 + ROWS * (COLS + 1) + (ROWS - 1), "done_latency",
          64'(done_cyc - start_cyc), 64'(1 + ROWS * (COLS + 1) + (ROWS - 1)));
    check(flush_cnt == ROWS - 1, "flush_count", 64'(flush_cnt), 64'(ROWS - 1));

    // Backpressure with random data
    ready_mode = 1;
    load_array(1);
    flush_cnt = 0;
    start_drain();
    wait_done(400);
    check(flush_cnt == ROWS - 1, "flush_count_bp", 64'(flush_cnt), 64'(ROWS - 1));

    // Signed extremes under random ready
    ready_mode = 2;
    for (int t = 0; t < 3; t++) begin
      load_array(2);
      start_drain();
      wait_done(400);
    end

    // START while busy (row 2 in SEND) is ignored
    ready_mode = 0;
    load_array(1);
    start_drain();
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge CLK);
      if (OUT_VALID && OUT_ROW == 2) found = 1;
    end
    check(found == 1, "reach_row2", 64'(found), 64'(1));
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    wait_done(200);
    repeat (40) @(posedge CLK);
    check(done_cnt == exp_done && !BUSY, "single_done", 64'(done_cnt), 64'(exp_done));

    // Reset during SHIFT, then restart from the shifted array contents
    ready_mode = 2;
    load_array(1);
    start_drain();
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge CLK);
      if (FLUSH_OUT) found = 1;
    end
    check(found == 1, "reach_shift", 64'(found), 64'(1));
    #1 RSTn = 1'b0;
    @(negedge CLK);
    check(!FLUSH_OUT && !OUT_VALID && !BUSY && !DONE, "mid_reset_outputs",
          64'({FLUSH_OUT, OUT_VALID, BUSY, DONE}), 64'(0));
    exp_q.delete();
    @(posedge CLK); #1 RSTn = 1'b1;
    repeat (3) @(posedge CLK);
    check(done_cnt == exp_done && !BUSY, "no_done_after_reset", 64'(done_cnt), 64'(exp_done));
    start_drain();
    wait_done(400);

    repeat (5) @(posedge CLK);
    check(done_cnt == exp_done, "total_done_count", 64'(done_cnt), 64'(exp_done));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
